// File: rtl/sin_controller.sv
// Control FSM for the Taylor-series sine datapath: sequences x^2, the term recurrence
// term <= term * x^2 * 1/((2k)(2k+1)) and the alternating-sign accumulation.
module sin_controller #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_n_terms,
    input  logic             i_mul_done,
    output logic             o_ready,
    output logic             o_done,
    output logic             o_init,
    output logic             o_ld_x2,
    output logic             o_ld_term,
    output logic             o_ld_sum,
    output logic             o_add_sub,
    output logic             o_mul_go,
    output logic [1:0]       o_mul_sel,
    output logic [CNT_W-1:0] o_coef_addr
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [3:0] {
        StIdle, StInit, StSq, StSqW, StChk, StM1, StM1W, StM2, StM2W, StAcc, StDone
    } state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_k;
    logic             r_ready;
    logic             r_done;
    logic             r_init;
    logic             r_ld_sum;
    logic             r_add_sub;
    logic             r_mul_go;
    logic [1:0]       r_mul_sel;
    logic [CNT_W-1:0] r_coef_addr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_n         <= '0;
            r_k         <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_init      <= 1'b0;
            r_ld_sum    <= 1'b0;
            r_add_sub   <= 1'b0;
            r_mul_go    <= 1'b0;
            r_mul_sel   <= 2'd0;
            r_coef_addr <= '0;
        end else begin
            // Pulse outputs default low; each transition raises those of its target state.
            r_done    <= 1'b0;
            r_init    <= 1'b0;
            r_ld_sum  <= 1'b0;
            r_add_sub <= 1'b0;
            r_mul_go  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_n     <= (i_n_terms == '0) ? CntOne : i_n_terms;
                        r_k     <= CntOne;
                        r_ready <= 1'b0;
                        r_init  <= 1'b1;
                        r_state <= StInit;
                    end
                end
                StInit: begin
                    r_mul_go  <= 1'b1;
                    r_mul_sel <= 2'd0;
                    r_state   <= StSq;
                end
                StSq: r_state <= StSqW;
                StSqW: begin
                    if (i_mul_done) begin
                        r_state <= StChk;
                    end
                end
                StChk: begin
                    if (r_k == r_n) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_mul_go  <= 1'b1;
                        r_mul_sel <= 2'd1;
                        r_state   <= StM1;
                    end
                end
                StM1: r_state <= StM1W;
                StM1W: begin
                    if (i_mul_done) begin
                        r_mul_go    <= 1'b1;
                        r_mul_sel   <= 2'd2;
                        r_coef_addr <= r_k - CntOne;
                        r_state     <= StM2;
                    end
                end
                StM2: r_state <= StM2W;
                StM2W: begin
                    if (i_mul_done) begin
                        r_mul_sel   <= 2'd0;
                        r_coef_addr <= '0;
                        r_ld_sum    <= 1'b1;
                        r_add_sub   <= r_k[0];
                        r_state     <= StAcc;
                    end
                end
                StAcc: begin
                    r_k     <= r_k + CntOne;
                    r_state <= StChk;
                end
                StDone: begin
                    r_ready <= 1'b1;
                    r_state <= StIdle;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Result loads must coincide with the mul_done pulse, so they cannot be registered.
    assign o_ld_x2   = (r_state == StSqW) && i_mul_done;
    assign o_ld_term = ((r_state == StM1W) || (r_state == StM2W)) && i_mul_done;

    assign o_ready     = r_ready;
    assign o_done      = r_done;
    assign o_init      = r_init;
    assign o_ld_sum    = r_ld_sum;
    assign o_add_sub   = r_add_sub;
    assign o_mul_go    = r_mul_go;
    assign o_mul_sel   = r_mul_sel;
    assign o_coef_addr = r_coef_addr;

endmodule

// File: tb/tb_sin_controller.sv
// Directed bench for sin_controller: latency-programmable multiplier model plus a
// Q.24 datapath model driven by the controller's load/select outputs.
module tb_sin_controller;

    localparam longint XIN = longint'(392) <<< 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_drv = 1'b1;
    logic       start_noise = 1'b0;
    logic       start_w;
    logic       mul_done = 1'b0;
    logic [7:0] n_terms = 8'd3;

    logic       o_ready, o_done, o_init, o_ld_x2, o_ld_term, o_ld_sum, o_add_sub, o_mul_go;
    logic [1:0] o_mul_sel;
    logic [7:0] o_coef_addr;

    assign start_w = start_drv | start_noise;

    sin_controller #(.CNT_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start_w),
        .i_n_terms   (n_terms),
        .i_mul_done  (mul_done),
        .o_ready     (o_ready),
        .o_done      (o_done),
        .o_init      (o_init),
        .o_ld_x2     (o_ld_x2),
        .o_ld_term   (o_ld_term),
        .o_ld_sum    (o_ld_sum),
        .o_add_sub   (o_add_sub),
        .o_mul_go    (o_mul_go),
        .o_mul_sel   (o_mul_sel),
        .o_coef_addr (o_coef_addr)
    );

    initial forever #5 clk = ~clk;

    int          nvec = 0;
    int          nfail = 0;
    int          rc = 1000;
    int          lat = 1;
    int          cnt = 0;
    logic [63:0] spur_mask = '0;
    logic [63:0] snoise_mask = '0;

    int          c_init, c_init2, c_go0, c_x2, c_done;
    int          n_init, n_go, n_x2, n_term, n_sum, excl_err, rdy_bad;
    logic [1:0]  sel0;
    logic        rdy_after, seen_done;
    logic [7:0]  as_bits;
    logic [23:0] ca_vals;
    longint      dp_x, dp_x2, dp_term, dp_sum;

    function automatic longint coef(input logic [7:0] a);
        longint d;
        d = (2 * longint'(a) + 2) * (2 * longint'(a) + 3);
        return (longint'(1) <<< 24) / d;
    endfunction

    function automatic longint sinx();
        return (dp_sum + (longint'(1) <<< 15)) >>> 16;
    endfunction

    function automatic longint idle_outs();
        return longint'({o_done, o_init, o_ld_x2, o_ld_term, o_ld_sum, o_add_sub, o_mul_go,
                         o_mul_sel, o_coef_addr});
    endfunction

    // Multiplier: mul_done L cycles after mul_go, plus injected spurious pulses.
    always @(posedge clk) begin
        logic md;
        #1;
        rc = rc + 1;
        md = 1'b0;
        if (cnt != 0) begin
            cnt = cnt - 1;
            if (cnt == 0) md = 1'b1;
        end
        if (o_mul_go) cnt = lat;
        mul_done    = md | ((rc < 64) ? spur_mask[rc[5:0]] : 1'b0);
        start_noise = (rc < 64) ? snoise_mask[rc[5:0]] : 1'b0;
    end

    always @(posedge clk) begin
        #3;
        if (int'(o_done) + int'(o_init) + int'(o_ld_x2) + int'(o_ld_term) + int'(o_ld_sum)
            + int'(o_mul_go) > 1) excl_err = excl_err + 1;
        if (!seen_done && o_ready) rdy_bad = rdy_bad + 1;
        if (o_init) begin
            n_init = n_init + 1;
            if (n_init == 1) c_init = rc;
            else c_init2 = rc;
            dp_x = XIN; dp_term = XIN; dp_sum = XIN;
        end
        if (o_mul_go) begin
            n_go = n_go + 1;
            if (n_go == 1) begin c_go0 = rc; sel0 = o_mul_sel; end
            if (o_mul_sel == 2'd2) ca_vals = {ca_vals[15:0], o_coef_addr};
        end
        if (o_ld_x2) begin
            c_x2 = rc; n_x2 = n_x2 + 1;
            dp_x2 = (dp_x * dp_x) >>> 24;
        end
        if (o_ld_term) begin
            n_term = n_term + 1;
            if (o_mul_sel == 2'd1) dp_term = (dp_term * dp_x2) >>> 24;
            else dp_term = (dp_term * coef(o_coef_addr)) >>> 24;
        end
        if (o_ld_sum) begin
            n_sum = n_sum + 1;
            as_bits = {as_bits[6:0], o_add_sub};
            dp_sum = o_add_sub ? dp_sum - dp_term : dp_sum + dp_term;
        end
        if (o_done && !seen_done) begin seen_done = 1'b1; c_done = rc; end
        if (seen_done && rc == c_done + 1) rdy_after = o_ready;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        nvec = nvec + 1;
        assert (obs === exp) else begin
            nfail = nfail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint exp,
                           input longint tol);
        nvec = nvec + 1;
        assert ((obs - exp <= tol) && (exp - obs <= tol)) else begin
            nfail = nfail + 1;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic clear_rec();
        c_init = 0; c_init2 = 0; c_go0 = 0; c_x2 = 0; c_done = 0; sel0 = 2'd3;
        n_init = 0; n_go = 0; n_x2 = 0; n_term = 0; n_sum = 0; excl_err = 0; rdy_bad = 0;
        rdy_after = 1'b0; seen_done = 1'b0; as_bits = '0; ca_vals = '0;
        dp_x = 0; dp_x2 = 0; dp_term = 0; dp_sum = 0;
    endtask

    // Start accepted at the edge after this call's first negedge (edge 0).
    task automatic run(input logic [7:0] nt, input int lt, input bit hold, input int budget);
        @(negedge clk);
        clear_rec();
        lat = lt; n_terms = nt; start_drv = 1'b1; rc = 0;
        @(negedge clk);
        start_drv = hold;
        if (!hold) n_terms = ~nt;
        for (int i = 0; i < budget; i++) begin
            if (seen_done && rc > c_done) break;
            @(negedge clk);
        end
    endtask

    initial begin
        longint golden;
        golden = longint'($rtoi($floor($sin(1.53125) * 256.0 + 0.5)));

        // Reset held with start high
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", longint'(o_ready), 1);
            chk("rst_outs", idle_outs(), 0);
        end
        rst = 1'b0; start_drv = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", longint'(o_ready), 1);
        chk("post_rst_outs", idle_outs(), 0);

        // n = 1, L = 1
        run(8'd1, 1, 1'b0, 100);
        chk("n1_init", c_init, 1);
        chk("n1_go", c_go0, 2);
        chk("n1_sel", longint'(sel0), 0);
        chk("n1_x2", c_x2, 3);
        chk("n1_done", c_done, 5);
        chk("n1_nsum", n_sum, 0);
        chk("n1_rdy_low", rdy_bad, 0);
        chk("n1_rdy_after", longint'(rdy_after), 1);
        chk("n1_sinx", sinx(), 392);

        // n = 4, L = 1, x = 0x0188 (Q.8)
        run(8'd4, 1, 1'b0, 100);
        chk("n4_done", c_done, 23);
        chk("n4_nsum", n_sum, 3);
        chk("n4_addsub", longint'(as_bits), 5);
        chk("n4_coef", longint'(ca_vals), 24'h000102);
        chk("n4_nterm", n_term, 6);
        chk("n4_excl", excl_err, 0);
        chk("n4_rdy_low", rdy_bad, 0);
        chk_tol("n4_sinx", sinx(), golden, 1);

        // n = 0 behaves as n = 1
        run(8'd0, 1, 1'b0, 100);
        chk("n0_init", c_init, 1);
        chk("n0_x2", c_x2, 3);
        chk("n0_done", c_done, 5);
        chk("n0_nsum", n_sum, 0);

        // n = 3, L = 4
        run(8'd3, 4, 1'b0, 100);
        chk("n3_x2", c_x2, 6);
        chk("n3_done", c_done, 32);
        chk("n3_addsub", longint'(as_bits), 2);
        chk("n3_excl", excl_err, 0);

        // n = 2, L = 2 with stray start and mul_done pulses outside wait states
        spur_mask   = 64'h3266;
        snoise_mask = 64'h3224;
        run(8'd2, 2, 1'b0, 100);
        spur_mask = '0; snoise_mask = '0;
        chk("nz_done", c_done, 14);
        chk("nz_ninit", n_init, 1);
        chk("nz_ngo", n_go, 3);
        chk("nz_nx2", n_x2, 1);
        chk("nz_nterm", n_term, 2);
        chk("nz_nsum", n_sum, 1);
        chk("nz_addsub", longint'(as_bits), 1);
        chk("nz_excl", excl_err, 0);

        // start held high: restart straight after DONE
        run(8'd1, 1, 1'b1, 100);
        @(negedge clk);
        start_drv = 1'b0;
        chk("hold_done", c_done, 5);
        chk("hold_restart", c_init2, 7);
        repeat (12) @(negedge clk);

        // Reset during M2_W of an n = 4, L = 3 run
        @(negedge clk);
        clear_rec();
        lat = 3; n_terms = 8'd4; start_drv = 1'b1; rc = 0;
        @(negedge clk);
        start_drv = 1'b0;
        for (int i = 0; i < 50 && rc < 12; i++) @(negedge clk);
        chk("m2w_sel", longint'(o_mul_sel), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", longint'(o_ready), 1);
        chk("mid_rst_outs", idle_outs(), 0);
        @(negedge clk);
        chk("stale_md_term", longint'(o_ld_term), 0);
        chk("stale_md_ready", longint'(o_ready), 1);

        run(8'd4, 1, 1'b0, 100);
        chk("rerun_done", c_done, 23);
        chk("rerun_nsum", n_sum, 3);
        chk("rerun_coef", longint'(ca_vals), 24'h000102);
        chk_tol("rerun_sinx", sinx(), golden, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
